univ_shift_reg: RTL



---
 rtl/univ_shift_reg.sv | 116 +++++++++++
 1 files changed

// File: rtl/univ_shift_reg.sv
// Parametrised universal shift register: hold, logical/arithmetic shifts,
// rotates, parallel load and soft clear, plus a saturating shift counter
// that reports when every loaded bit has been shifted out.

// Per-bit next-value select. from_hi is the bit arriving on a right-moving
// operation, from_lo is the bit arriving on a left-moving operation.
module usr_cell (
  input  logic [2:0] mode,
  input  logic       cur,
  input  logic       from_hi,
  input  logic       from_lo,
  input  logic       ld,
  output logic       nxt
);
  // One mux per bit; end-of-register fill is resolved by the parent.
  always_comb begin
    nxt = cur;
    case (mode)
      3'b000:                 nxt = cur;
      3'b001, 3'b100, 3'b110: nxt = from_hi;
      3'b010, 3'b101:         nxt = from_lo;
      3'b011:                 nxt = ld;
      3'b111:                 nxt = 1'b0;
      default:                nxt = cur;
    endcase
  end
endmodule

module univ_shift_reg #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic [CW-1:0]    cnt,
  output logic             drained
);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  logic [WIDTH-1:0] q_nxt;
  logic             top_fill;
  logic             bot_fill;

  // Bit entering the MSB on right-moving ops: serial in, wrap, or sign copy.
  always_comb begin
    top_fill = sin_r;
    case (mode)
      3'b100:  top_fill = q[0];
      3'b110:  top_fill = q[WIDTH-1];
      default: top_fill = sin_r;
    endcase
  end

  // Bit entering the LSB on left-moving ops: serial in or wrap.
  always_comb begin
    bot_fill = (mode == 3'b101) ? q[WIDTH-1] : sin_l;
  end

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      logic hi, lo;
      if (i == WIDTH - 1) begin : g_top
        assign hi = top_fill;
      end else begin : g_mid_hi
        assign hi = q[i+1];
      end
      if (i == 0) begin : g_bot
        assign lo = bot_fill;
      end else begin : g_mid_lo
        assign lo = q[i-1];
      end
      usr_cell u_cell (
        .mode    (mode),
        .cur     (q[i]),
        .from_hi (hi),
        .from_lo (lo),
        .ld      (d[i]),
        .nxt     (q_nxt[i])
      );
    end
  endgenerate

  // Register contents; clear beats enable, enable beats mode.
  always_ff @(posedge clk) begin
    if (clear)   q <= '0;
    else if (en) q <= q_nxt;
  end

  // Shift counter: load zeroes it, shifts saturate it at WIDTH,
  // rotates and hold leave it alone, soft clear marks it drained.
  always_ff @(posedge clk) begin
    if (clear) begin
      cnt <= FULL;
    end else if (en) begin
      case (mode)
        3'b011:                 cnt <= '0;
        3'b111:                 cnt <= FULL;
        3'b001, 3'b010, 3'b110: if (cnt != FULL) cnt <= cnt + 1'b1;
        default:                cnt <= cnt;
      endcase
    end
  end

  assign sout_r  = q[0];
  assign sout_l  = q[WIDTH-1];
  assign drained = (cnt == FULL);
endmodule
